// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one byte per data_valid strobe, LSB first, fixed bit period.
// All outputs are registered; the FSM state is exposed on state_dbg.
module uart_tx_serializer #(
  parameter int CLOCKS_PER_BIT = 217
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_valid,
  input  logic [7:0] data_in,
  output logic       transmitting,
  output logic       serial_out,
  output logic       transmission_done,
  output logic [2:0] state_dbg
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] counter, counter_n;
  logic [2:0]    index, index_n;
  logic [7:0]    shift_reg, shift_n;
  logic          serial_n, tx_n, done_n;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      counter           <= '0;
      index             <= '0;
      shift_reg         <= '0;
      serial_out        <= 1'b1;
      transmitting      <= 1'b0;
      transmission_done <= 1'b0;
    end else begin
      state             <= state_n;
      counter           <= counter_n;
      index             <= index_n;
      shift_reg         <= shift_n;
      serial_out        <= serial_n;
      transmitting      <= tx_n;
      transmission_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    counter_n = counter;
    index_n   = index;
    shift_n   = shift_reg;
    serial_n  = serial_out;
    tx_n      = transmitting;
    done_n    = transmission_done;
    case (state)
      IDLE: begin
        serial_n = 1'b1;
        tx_n     = 1'b0;
        done_n   = 1'b0;
        if (data_valid) begin
          shift_n   = data_in;
          serial_n  = 1'b0;
          tx_n      = 1'b1;
          counter_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (counter == LAST) begin
          counter_n = '0;
          index_n   = '0;
          serial_n  = shift_reg[0];
          state_n   = DATA;
        end else begin
          counter_n = counter + CW'(1);
        end
      end
      DATA: begin
        if (counter == LAST) begin
          counter_n = '0;
          if (index == 3'd7) begin
            serial_n = 1'b1;
            state_n  = STOP;
          end else begin
            index_n  = index + 3'd1;
            serial_n = shift_reg[index + 3'd1];
          end
        end else begin
          counter_n = counter + CW'(1);
        end
      end
      STOP: begin
        if (counter == LAST) begin
          counter_n = '0;
          tx_n      = 1'b0;
          done_n    = 1'b1;
          state_n   = CLEANUP;
        end else begin
          counter_n = counter + CW'(1);
        end
      end
      CLEANUP: begin
        // The edge leaving CLEANUP can already accept the next byte,
        // giving 10*CLOCKS_PER_BIT+1 cycles between start bits.
        done_n  = 1'b0;
        state_n = IDLE;
        if (data_valid) begin
          shift_n   = data_in;
          serial_n  = 1'b0;
          tx_n      = 1'b1;
          counter_n = '0;
          state_n   = START;
        end
      end
      default: begin
        state_n  = IDLE;
        serial_n = 1'b1;
        tx_n     = 1'b0;
        done_n   = 1'b0;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (217, 4, 2 clocks per bit) driven by
// directed steps; expected line bits are queued at stimulus time and popped mid-bit.
module tb_uart_tx_serializer;

  logic       clock = 1'b0;
  logic       rst_n [3];
  logic       valid [3];
  logic [7:0] din   [3];
  logic       ser   [3];
  logic       trn   [3];
  logic       dn    [3];
  logic [2:0] st    [3];

  int compared   = 0;
  int mismatched = 0;
  logic [0:0] exp_q[$];

  always #20 clock = ~clock;

  uart_tx_serializer #(.CLOCKS_PER_BIT(217)) u_217 (
    .clock(clock), .reset(rst_n[0]), .data_valid(valid[0]), .data_in(din[0]),
    .transmitting(trn[0]), .serial_out(ser[0]), .transmission_done(dn[0]), .state_dbg(st[0]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(4)) u_4 (
    .clock(clock), .reset(rst_n[1]), .data_valid(valid[1]), .data_in(din[1]),
    .transmitting(trn[1]), .serial_out(ser[1]), .transmission_done(dn[1]), .state_dbg(st[1]));
  uart_tx_serializer #(.CLOCKS_PER_BIT(2)) u_2 (
    .clock(clock), .reset(rst_n[2]), .data_valid(valid[2]), .data_in(din[2]),
    .transmitting(trn[2]), .serial_out(ser[2]), .transmission_done(dn[2]), .state_dbg(st[2]));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic idle_check(input int d, input int n);
    repeat (n) begin
      @(negedge clock);
      check("idle_serial", 8'(ser[d]), 8'd1);
      check("idle_transmitting", 8'(trn[d]), 8'd0);
      check("idle_done", 8'(dn[d]), 8'd0);
    end
  endtask

  task automatic start_frame(input int d, input logic [7:0] b);
    @(negedge clock);
    valid[d] = 1'b1;
    din[d]   = b;
  endtask

  // j counts negedges after the accepting posedge; the frame spans j = 0 .. 10*cpb-1.
  task automatic observe(input int d, input int cpb, input logic keep,
                         input logic [7:0] after, input int inj);
    logic [0:0] e;
    for (int j = 0; j <= 10 * cpb; j++) begin
      @(negedge clock);
      if (j == 0) begin
        valid[d] = keep;
        din[d]   = after;
        check("start_bit_first_cycle", 8'(ser[d]), 8'd0);
      end
      if (j == inj) begin
        valid[d] = 1'b1;
        din[d]   = 8'h00;
      end
      if (inj >= 0 && j == inj + 1) valid[d] = 1'b0;
      check("transmitting", 8'(trn[d]), 8'(j < 10 * cpb));
      check("done", 8'(dn[d]), 8'(j == 10 * cpb));
      if (j < 10 * cpb && (j % cpb) == cpb / 2) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 8'(exp_q.size()), 8'd1);
        end else begin
          e = exp_q.pop_front();
          check("line_bit", 8'(ser[d]), 8'(e));
        end
      end
      if (j == 10 * cpb) check("line_after_stop", 8'(ser[d]), 8'd1);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0;
      valid[d] = 1'b0;
      din[d]   = 8'h00;
    end

    // Reset values, including strobes that must be ignored while in reset
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      valid[d] = 1'b1;
      din[d]   = 8'hFF;
    end
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++) begin
      check("reset_serial", 8'(ser[d]), 8'd1);
      check("reset_transmitting", 8'(trn[d]), 8'd0);
      check("reset_done", 8'(dn[d]), 8'd0);
      check("reset_state", 8'(st[d]), 8'd0);
      valid[d] = 1'b0;
    end
    @(negedge clock);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    for (int d = 0; d < 3; d++) idle_check(d, 2);

    // Basic frame at 217 clocks per bit
    push_frame(8'h3F);
    start_frame(0, 8'h3F);
    observe(0, 217, 1'b0, 8'($urandom_range(0, 255)), -1);
    idle_check(0, 3);

    // Busy rejection: a strobe of 0x00 during data bit 3 is dropped
    push_frame(8'hA5);
    start_frame(1, 8'hA5);
    observe(1, 4, 1'b0, 8'($urandom_range(0, 255)), 18);
    idle_check(1, 12);

    // Asynchronous reset during data bit 3 of 0x00
    start_frame(1, 8'h00);
    @(negedge clock);
    valid[1] = 1'b0;
    repeat (18) @(negedge clock);
    check("midframe_busy_before_reset", 8'(trn[1]), 8'd1);
    rst_n[1] = 1'b0;
    #1;
    check("async_reset_serial", 8'(ser[1]), 8'd1);
    check("async_reset_transmitting", 8'(trn[1]), 8'd0);
    check("async_reset_done", 8'(dn[1]), 8'd0);
    check("async_reset_state", 8'(st[1]), 8'd0);
    idle_check(1, 4);
    @(negedge clock);
    rst_n[1] = 1'b1;
    idle_check(1, 3);
    push_frame(8'h81);
    start_frame(1, 8'h81);
    observe(1, 4, 1'b0, 8'($urandom_range(0, 255)), -1);
    idle_check(1, 3);

    // Back-to-back with data_valid held high: second start bit 41 cycles after the first
    push_frame(8'h55);
    push_frame(8'hFF);
    start_frame(1, 8'h55);
    observe(1, 4, 1'b1, 8'hFF, -1);
    observe(1, 4, 1'b0, 8'($urandom_range(0, 255)), -1);
    idle_check(1, 3);

    // Minimum divider
    push_frame(8'h80);
    start_frame(2, 8'h80);
    observe(2, 2, 1'b0, 8'($urandom_range(0, 255)), -1);
    idle_check(2, 3);

    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
